// File: rtl/servant_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// servant_arb_pkg
// Shared types and constants for the servant RAM arbiter and its
// round-robin picker.
//   arb_state_e     : arbiter FSM state (IDLE, BUSY)
//   GNT_*           : one-hot grant encodings (bit0 = CPU, bit1 = proc)
//   LAST_*          : encoding of the last-served requester
//   DEF_TIMEOUT     : default ack watchdog limit in cycles
//   DEF_ERR_DATA    : default read data returned on a timed-out access
// ---------------------------------------------------------------------------
package servant_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam logic [1:0] GNT_NONE = 2'b00;
   localparam logic [1:0] GNT_CPU  = 2'b01;
   localparam logic [1:0] GNT_PROC = 2'b10;

   // Matches bit1 of the one-hot grant, so last can be taken from grant[1].
   localparam logic LAST_CPU  = 1'b0;
   localparam logic LAST_PROC = 1'b1;

   localparam int unsigned DEF_TIMEOUT  = 15;
   localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/servant_ram_arbiter_rr.sv
// ---------------------------------------------------------------------------
// servant_arb_rr
// Two-input round-robin picker, purely combinational. Usable in front of
// any shared slave with a CPU-side and a proc-side requester.
//   req_i       : request vector, bit0 = CPU, bit1 = proc
//   last_i      : requester served last (LAST_CPU / LAST_PROC)
//   prio_proc_i : when set, proc wins every tie regardless of last_i
//   win_o       : one-hot winner, zero when nobody requests
// ---------------------------------------------------------------------------
module servant_arb_rr
   import servant_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  logic       last_i,
   input  logic       prio_proc_i,
   output logic [1:0] win_o
);

   always_comb begin
      win_o = req_i;
      // Tie: the side that was not served last wins, unless proc has priority.
      if (req_i == 2'b11) begin
         win_o = (prio_proc_i || (last_i == LAST_CPU)) ? GNT_PROC : GNT_CPU;
      end
   end

endmodule

// File: rtl/servant_ram_arbiter.sv
// ---------------------------------------------------------------------------
// servant_ram_arbiter
// Shares the single-port servant RAM between the CPU memory bus and the
// external processor/debug bus. One transaction at a time, registered grant,
// an IDLE cycle between transactions, and an ack watchdog that completes a
// stuck access with ERR_DATA and raises a sticky timeout flag.
//
// Ports:
//   wb_clk, wb_rst          : clock, synchronous active-high reset
//   i_wb_cpu_*  / o_wb_cpu_*  : CPU Wishbone master side (request = cyc)
//   i_wb_proc_* / o_wb_proc_* : proc Wishbone master side (request = stb)
//   o_wb_mem_*  / i_wb_mem_*  : RAM slave side, word address [AW-1:2]
//   o_grant                 : registered one-hot owner (bit0 CPU, bit1 proc)
//   o_timeout               : sticky, set on any watchdog expiry
//
// Build option: SERVANT_ARB_PROC_PRIORITY_EN selects fixed proc priority on
// ties (CPU may starve); otherwise ties are round-robin.
// ---------------------------------------------------------------------------
module servant_ram_arbiter
   import servant_arb_pkg::*;
#(
   parameter int unsigned AW       = 13,
   parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
   parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   input  logic [31:0]   i_wb_cpu_adr,
   input  logic [31:0]   i_wb_cpu_dat,
   input  logic [3:0]    i_wb_cpu_sel,
   input  logic          i_wb_cpu_we,
   input  logic          i_wb_cpu_cyc,
   output logic [31:0]   o_wb_cpu_rdt,
   output logic          o_wb_cpu_ack,
   input  logic [31:0]   i_wb_proc_adr,
   input  logic [31:0]   i_wb_proc_dat,
   input  logic [3:0]    i_wb_proc_sel,
   input  logic          i_wb_proc_we,
   input  logic          i_wb_proc_stb,
   output logic [31:0]   o_wb_proc_rdt,
   output logic          o_wb_proc_ack,
   output logic [AW-3:0] o_wb_mem_adr,
   output logic [31:0]   o_wb_mem_dat,
   output logic [3:0]    o_wb_mem_sel,
   output logic          o_wb_mem_we,
   output logic          o_wb_mem_cyc,
   input  logic [31:0]   i_wb_mem_rdt,
   input  logic          i_wb_mem_ack,
   output logic [1:0]    o_grant,
   output logic          o_timeout
);

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

`ifdef SERVANT_ARB_PROC_PRIORITY_EN
   localparam logic PRIO_PROC = 1'b1;
`else
   localparam logic PRIO_PROC = 1'b0;
`endif

   arb_state_e  state_q;
   logic [1:0]  grant_q;
   logic        last_q;
   logic [7:0]  wd_q;
   logic        timeout_q;

   logic [1:0]  req;
   logic [1:0]  win_d;
   logic        busy;
   logic        wd_exp;
   logic        done;
   logic [31:0] ack_rdt;

   // Byte offset and bits above the RAM size are not decoded.
   logic        unused_adr_bits;
   assign unused_adr_bits = ^{i_wb_cpu_adr[31:AW], i_wb_cpu_adr[1:0],
                              i_wb_proc_adr[31:AW], i_wb_proc_adr[1:0]};

   assign req = {i_wb_proc_stb, i_wb_cpu_cyc};

   servant_arb_rr u_rr (
      .req_i       (req),
      .last_i      (last_q),
      .prio_proc_i (PRIO_PROC),
      .win_o       (win_d)
   );

   assign busy   = (state_q == BUSY);
   // A real RAM ack in the limit cycle takes precedence over the watchdog.
   assign wd_exp = busy && (wd_q == WD_LIMIT) && !i_wb_mem_ack;
   // Reset in the completing cycle aborts the access without an ack.
   assign done   = busy && (i_wb_mem_ack || wd_exp) && !wb_rst;
   assign ack_rdt = wd_exp ? ERR_DATA : i_wb_mem_rdt;

   assign o_wb_cpu_ack  = done && grant_q[0];
   assign o_wb_proc_ack = done && grant_q[1];
   assign o_wb_cpu_rdt  = grant_q[0] ? ack_rdt : '0;
   assign o_wb_proc_rdt = grant_q[1] ? ack_rdt : '0;

   assign o_wb_mem_cyc = busy;
   assign o_grant      = grant_q;
   assign o_timeout    = timeout_q;

   // Request mux steered by the registered grant, zero when idle.
   always_comb begin
      o_wb_mem_adr = '0;
      o_wb_mem_dat = '0;
      o_wb_mem_sel = '0;
      o_wb_mem_we  = 1'b0;
      case (grant_q)
         GNT_CPU: begin
            o_wb_mem_adr = i_wb_cpu_adr[AW-1:2];
            o_wb_mem_dat = i_wb_cpu_dat;
            o_wb_mem_sel = i_wb_cpu_sel;
            o_wb_mem_we  = i_wb_cpu_we;
         end
         GNT_PROC: begin
            o_wb_mem_adr = i_wb_proc_adr[AW-1:2];
            o_wb_mem_dat = i_wb_proc_dat;
            o_wb_mem_sel = i_wb_proc_sel;
            o_wb_mem_we  = i_wb_proc_we;
         end
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         state_q   <= IDLE;
         grant_q   <= GNT_NONE;
         last_q    <= LAST_PROC;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req) begin
                  state_q <= BUSY;
                  grant_q <= win_d;
                  wd_q    <= '0;
               end
            end
            BUSY: begin
               if (wd_q != 8'hFF) wd_q <= wd_q + 8'd1;
               if (wd_exp) timeout_q <= 1'b1;
               // Completion always passes through IDLE, so the RAM never
               // sees cyc held across an ack.
               if (done) begin
                  state_q <= IDLE;
                  grant_q <= GNT_NONE;
                  last_q  <= grant_q[1];
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_servant_ram_arbiter.sv
module tb_servant_ram_arbiter;

   localparam int AW = 13;
   localparam int TO = 15;
   localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef SERVANT_ARB_PROC_PRIORITY_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic        wb_clk = 1'b0;
   logic        wb_rst;
   logic [31:0] cpu_adr, cpu_dat, cpu_rdt;
   logic [3:0]  cpu_sel;
   logic        cpu_we, cpu_cyc, cpu_ack;
   logic [31:0] proc_adr, proc_dat, proc_rdt;
   logic [3:0]  proc_sel;
   logic        proc_we, proc_stb, proc_ack;
   logic [10:0] mem_adr;
   logic [31:0] mem_dat;
   logic [3:0]  mem_sel;
   logic        mem_we, mem_cyc;
   logic [31:0] ram_rdt;
   logic        ram_ack;
   logic [1:0]  grant;
   logic        tout;

   int n_chk = 0;
   int n_err = 0;

   always #5 wb_clk = ~wb_clk;

   servant_ram_arbiter #(.AW(AW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst),
      .i_wb_cpu_adr(cpu_adr), .i_wb_cpu_dat(cpu_dat), .i_wb_cpu_sel(cpu_sel),
      .i_wb_cpu_we(cpu_we), .i_wb_cpu_cyc(cpu_cyc),
      .o_wb_cpu_rdt(cpu_rdt), .o_wb_cpu_ack(cpu_ack),
      .i_wb_proc_adr(proc_adr), .i_wb_proc_dat(proc_dat), .i_wb_proc_sel(proc_sel),
      .i_wb_proc_we(proc_we), .i_wb_proc_stb(proc_stb),
      .o_wb_proc_rdt(proc_rdt), .o_wb_proc_ack(proc_ack),
      .o_wb_mem_adr(mem_adr), .o_wb_mem_dat(mem_dat), .o_wb_mem_sel(mem_sel),
      .o_wb_mem_we(mem_we), .o_wb_mem_cyc(mem_cyc),
      .i_wb_mem_rdt(ram_rdt), .i_wb_mem_ack(ram_ack),
      .o_grant(grant), .o_timeout(tout)
   );

   // ---------------- RAM model: registered ack after ram_dly cycles of cyc
   function automatic logic [31:0] init_word(int i);
      return (i == 32'h40) ? 32'h12345678 : 32'hAAAAAAAA;
   endfunction

   logic [31:0] ram [0:2047];
   bit ram_inited = 1'b0;
   bit ram_en     = 1'b1;
   bit ram_rand   = 1'b0;
   int ram_cnt    = 0;
   int ram_dly    = 1;

   always @(posedge wb_clk) begin
      if (!ram_inited) begin
         for (int i = 0; i < 2048; i++) ram[i] <= init_word(i);
         ram_inited <= 1'b1;
      end
      if (!mem_cyc) begin
         ram_ack <= 1'b0;
         ram_cnt <= 0;
         if (ram_rand)
            ram_dly <= ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(1, 3));
         else
            ram_dly <= 1;
      end else if (ram_ack) begin
         ram_ack <= 1'b0;
         ram_cnt <= 0;
      end else begin
         ram_cnt <= ram_cnt + 1;
         if (ram_en && (ram_cnt + 1 >= ram_dly)) begin
            ram_ack <= 1'b1;
            ram_rdt <= ram[mem_adr];
            if (mem_we)
               for (int b = 0; b < 4; b++)
                  if (mem_sel[b]) ram[mem_adr][8*b +: 8] <= mem_dat[8*b +: 8];
         end
      end
   end

   // ---------------- helpers
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_adr = '0; cpu_dat = '0; cpu_sel = '0; cpu_we = 1'b0; cpu_cyc = 1'b0;
      proc_adr = '0; proc_dat = '0; proc_sel = '0; proc_we = 1'b0; proc_stb = 1'b0;
   endtask

   task automatic do_reset();
      wb_rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge wb_clk);
      #1 wb_rst = 1'b0;
   endtask

   // One transaction from a single master, request raised in cycle N.
   // lat = cycles from N to the ack; g1/a1/c1 sampled in cycle N+1.
   task automatic xfer(input bit who, input bit we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       output logic [31:0] rdt, output int lat,
                       output logic [1:0] g1, output logic [10:0] a1,
                       output logic c1, output bit other_ack);
      lat = -1; other_ack = 1'b0; rdt = '0; g1 = '0; a1 = '0; c1 = 1'b0;
      if (!who) begin cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_cyc = 1'b1; end
      else begin proc_adr = adr; proc_dat = dat; proc_sel = sel; proc_we = we; proc_stb = 1'b1; end
      for (int c = 0; c < 40; c++) begin
         @(negedge wb_clk);
         if (c == 1) begin g1 = grant; a1 = mem_adr; c1 = mem_cyc; end
         if (who ? cpu_ack : proc_ack) other_ack = 1'b1;
         if (who ? proc_ack : cpu_ack) begin
            lat = c;
            rdt = who ? proc_rdt : cpu_rdt;
            break;
         end
      end
      @(posedge wb_clk); #1;
      idle_inputs();
   endtask

   typedef struct {
      bit          who;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      bit          chk_rd;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[8];

   // ---------------- random-phase reference model state
   logic [31:0] shadow [0:2047];
   bit          pend[2];
   bit          ackd[2];
   logic [31:0] r_adr[2], r_dat[2];
   logic [3:0]  r_sel[2];
   bit          r_we[2];

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rdt;
      logic [1:0]  g1;
      logic [10:0] a1;
      logic        c1;
      bit          oth;
      int          lat, got, n;
      bit          hit;

      tbl[0] = '{0, 0, 32'h0000_0100, 32'h0,         4'hF,    1, 32'h1234_5678};
      tbl[1] = '{1, 1, 32'h0000_0200, 32'hCAFE_F00D, 4'b0011, 0, 32'h0};
      tbl[2] = '{0, 0, 32'h0000_0200, 32'h0,         4'hF,    1, 32'hAAAA_F00D};
      tbl[3] = '{0, 1, 32'h0000_0104, 32'h1122_3344, 4'hF,    0, 32'h0};
      tbl[4] = '{1, 0, 32'h0000_0104, 32'h0,         4'hF,    1, 32'h1122_3344};
      tbl[5] = '{1, 1, 32'h0000_0100, 32'h5566_9999, 4'b1100, 0, 32'h0};
      tbl[6] = '{0, 0, 32'hFFFF_E100, 32'h0,         4'hF,    1, 32'h5566_5678};
      tbl[7] = '{1, 0, 32'h0000_0103, 32'h0,         4'hF,    1, 32'h5566_5678};

      do_reset();
      @(negedge wb_clk);
      chk("rst_grant", grant, 2'b00);
      chk("rst_cyc", mem_cyc, 1'b0);
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_proc_ack", proc_ack, 1'b0);
      chk("rst_timeout", tout, 1'b0);
      @(posedge wb_clk); #1;

      // ---- table-driven single-master transactions
      for (int i = 0; i < 8; i++) begin
         xfer(tbl[i].who, tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel, rdt, lat, g1, a1, c1, oth);
         chk($sformatf("v%0d_latency", i), lat, 2);
         chk($sformatf("v%0d_cyc_n1", i), c1, 1'b1);
         chk($sformatf("v%0d_grant", i), g1, tbl[i].who ? 2'b10 : 2'b01);
         chk($sformatf("v%0d_mem_adr", i), a1, tbl[i].adr[12:2]);
         chk($sformatf("v%0d_other_ack", i), oth, 1'b0);
         if (tbl[i].chk_rd) chk($sformatf("v%0d_rdt", i), rdt, tbl[i].exp);
      end

      // ---- continuous dual requests
      do_reset();
      cpu_adr = 32'h100; cpu_cyc = 1'b1; proc_adr = 32'h104; proc_stb = 1'b1;
      got = 0;
      for (int c = 0; c < 80 && got < 6; c++) begin
         @(negedge wb_clk);
         if (cpu_ack || proc_ack) begin
            chk($sformatf("tie_grant%0d", got), grant,
                (PRIO || (got % 2 == 1)) ? 2'b10 : 2'b01);
            got++;
         end
      end
      chk("tie_count", got, 6);
      @(posedge wb_clk); #1 proc_stb = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge wb_clk);
         if (cpu_ack) begin hit = 1'b1; break; end
      end
      chk("cpu_after_proc_drop", hit, 1'b1);
      @(posedge wb_clk); #1 idle_inputs();

      // ---- watchdog timeout
      ram_en = 1'b0;
      xfer(0, 0, 32'h300, 32'h0, 4'hF, rdt, lat, g1, a1, c1, oth);
      ram_en = 1'b1;
      chk("to_latency", lat, 1 + TO);
      chk("to_rdt", rdt, ERR);
      chk("to_flag", tout, 1'b1);
      repeat (4) @(posedge wb_clk);
      #1 chk("to_flag_sticky", tout, 1'b1);
      xfer(1, 0, 32'h100, 32'h0, 4'hF, rdt, lat, g1, a1, c1, oth);
      chk("to_after_rdt", rdt, 32'h5566_5678);
      chk("to_flag_sticky2", tout, 1'b1);

      // ---- request dropped during BUSY still acks exactly once
      cpu_adr = 32'h100; cpu_cyc = 1'b1;
      @(posedge wb_clk); #1 cpu_cyc = 1'b0;
      n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge wb_clk);
         if (cpu_ack) n++;
      end
      chk("drop_ack_once", n, 1);

      // ---- reset mid-transaction with proc granted (CPU served last)
      @(posedge wb_clk); #1;
      xfer(0, 0, 32'h100, 32'h0, 4'hF, rdt, lat, g1, a1, c1, oth);
      proc_adr = 32'h104; proc_stb = 1'b1;
      @(posedge wb_clk); #1;
      @(negedge wb_clk);
      chk("mid_grant_proc", grant, 2'b10);
      @(posedge wb_clk); #1 wb_rst = 1'b1;
      @(negedge wb_clk);
      chk("mid_no_ack_in_rst", proc_ack, 1'b0);
      @(posedge wb_clk); #1 wb_rst = 1'b0; proc_stb = 1'b0;
      @(negedge wb_clk);
      chk("mid_cyc_low", mem_cyc, 1'b0);
      chk("mid_grant_none", grant, 2'b00);
      chk("mid_no_ack", proc_ack, 1'b0);
      chk("mid_timeout_clr", tout, 1'b0);
      @(posedge wb_clk); #1;
      cpu_adr = 32'h100; cpu_cyc = 1'b1; proc_adr = 32'h104; proc_stb = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge wb_clk);
         if (mem_cyc) begin hit = 1'b1; break; end
      end
      chk("post_rst_tie_seen", hit, 1'b1);
      chk("post_rst_tie_grant", grant, PRIO ? 2'b10 : 2'b01);
      for (int c = 0; c < 10; c++) begin
         if (cpu_ack || proc_ack) break;
         @(negedge wb_clk);
      end
      @(posedge wb_clk); #1 idle_inputs();

      // ---- randomized traffic against a transaction-level model
      do_reset();
      ram_rand = 1'b1;
      for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
      // RAM words touched by the directed tests
      shadow[32'h40] = 32'h5566_5678;
      shadow[32'h41] = 32'h1122_3344;
      shadow[32'h80] = 32'hAAAA_F00D;
      begin
         int          cur, last_srv, bcnt, idx;
         bit          m_to;
         logic [1:0]  eg, ea;
         logic [31:0] erd;
         bit          has_rd;
         cur = -1; last_srv = 1; bcnt = 0; m_to = 1'b0;
         pend[0] = 0; pend[1] = 0; ackd[0] = 0; ackd[1] = 0;
         for (int cy = 0; cy < 600; cy++) begin
            // masters: hold a request until acked, then maybe issue another
            for (int m = 0; m < 2; m++) begin
               if (ackd[m]) pend[m] = 1'b0;
               if (!pend[m] && $urandom_range(0, 3) != 0) begin
                  pend[m]  = 1'b1;
                  r_adr[m] = {$urandom_range(0, 32'h7FFFF), 2'b00, 11'h100} << 2
                             | 32'($urandom_range(0, 7)) << 2 | 32'($urandom_range(0, 3));
                  r_dat[m] = $urandom();
                  r_sel[m] = 4'($urandom_range(1, 15));
                  r_we[m]  = $urandom_range(0, 1) == 1;
               end
            end
            cpu_cyc  = pend[0]; cpu_adr  = r_adr[0]; cpu_dat  = r_dat[0];
            cpu_sel  = r_sel[0]; cpu_we  = r_we[0];
            proc_stb = pend[1]; proc_adr = r_adr[1]; proc_dat = r_dat[1];
            proc_sel = r_sel[1]; proc_we = r_we[1];
            @(negedge wb_clk);
            eg = 2'b00; ea = 2'b00; erd = '0; has_rd = 1'b0; idx = 0;
            if (cur >= 0) begin
               eg  = (cur == 0) ? 2'b01 : 2'b10;
               idx = int'(r_adr[cur][12:2]);
               if (ram_ack || bcnt == TO) begin
                  ea = eg;
                  if (!r_we[cur]) begin
                     has_rd = 1'b1;
                     erd = ram_ack ? shadow[idx] : ERR;
                  end
               end
            end
            chk("rnd_grant", grant, eg);
            chk("rnd_cyc", mem_cyc, cur >= 0);
            chk("rnd_cpu_ack", cpu_ack, ea[0]);
            chk("rnd_proc_ack", proc_ack, ea[1]);
            chk("rnd_timeout", tout, m_to);
            if (cur >= 0) chk("rnd_mem_adr", mem_adr, r_adr[cur][12:2]);
            if (has_rd) chk("rnd_rdt", (cur == 0) ? cpu_rdt : proc_rdt, erd);
            ackd[0] = cpu_ack; ackd[1] = proc_ack;
            // advance the model to the next cycle
            if (cur >= 0) begin
               if (ea != 2'b00) begin
                  if (ram_ack && r_we[cur])
                     for (int b = 0; b < 4; b++)
                        if (r_sel[cur][b]) shadow[idx][8*b +: 8] = r_dat[cur][8*b +: 8];
                  if (!ram_ack) m_to = 1'b1;
                  last_srv = cur;
                  cur = -1;
               end else begin
                  bcnt++;
               end
            end else begin
               bcnt = 0;
               if (pend[0] && pend[1]) cur = (PRIO || last_srv == 0) ? 1 : 0;
               else if (pend[0]) cur = 0;
               else if (pend[1]) cur = 1;
            end
            @(posedge wb_clk); #1;
         end
      end
      idle_inputs();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
